// File: rtl/otter_arb_pkg.sv
// Shared types for the OTTER data-memory arbiter.
//  arb_state_t   : arbiter FSM states
//  DBG_SIZE_WORD : access size the debug requester always uses (full word)
//  mem_req_t     : one memory-port request; used for the CPU side, the DBG
//                  side and the muxed port
//  dbg_to_req    : packs the debug fields into a full word request
package otter_arb_pkg;

  typedef enum logic [1:0] {
    S_CPU    = 2'd0,
    S_DBG_RD = 2'd1,
    S_DBG_WR = 2'd2
  } arb_state_t;

  localparam logic [1:0] DBG_SIZE_WORD = 2'b10;

  typedef struct packed {
    logic        rden;
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [1:0]  size;
    logic        sign;
  } mem_req_t;

  function automatic mem_req_t dbg_to_req(input logic        we,
                                          input logic [31:0] addr,
                                          input logic [31:0] din);
    mem_req_t r;
    r.rden = ~we;
    r.we   = we;
    r.addr = addr;
    r.din  = din;
    r.size = DBG_SIZE_WORD;
    r.sign = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/otter_starve_counter.sv
// Starvation guard for the debug requester.
// Counts consecutive cycles a debug request waits without a grant and flags
// starvation once the count reaches MAX_WAIT. The count saturates there.
// Ports:
//  CLK, RESET  clock, synchronous active-high reset
//  i_inc       debug request waiting this cycle (requested, not granted)
//  i_clr       request granted or withdrawn; restart the count
//  o_starve    count has reached MAX_WAIT
module otter_starve_counter
  import otter_arb_pkg::*;
#(
  parameter int CNT_W    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic CLK,
  input  logic RESET,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_starve
);

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (RESET || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt < LP_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // With MAX_WAIT = 0 this is constantly high: every request is forced.
  assign o_starve = (r_cnt >= LP_MAX);

endmodule

// File: rtl/otter_dmem_arbiter.sv
// Data-memory port 2 arbiter between the pipeline MEM stage (CPU) and a
// debug/loader requester (DBG). CPU has priority; DBG takes idle cycles.
// Optional macro OTTER_ARB_STARVE_EN adds a starvation guard that forces a DBG
// slot after MAX_WAIT waiting cycles and stalls the CPU for that one cycle.
// Ports:
//  CLK, RESET                      clock, synchronous active-high reset
//  cpu_rden/we/addr/din/size/sign  CPU request from EX/MEM
//  cpu_dout                        read data to MEM/WB (MEM_DOUT2 passthrough)
//  cpu_stall                       freeze the pipeline this cycle
//  dbg_req/we/addr/din             DBG request, held until dbg_ack
//  dbg_ack                         DBG access issued this cycle
//  dbg_rdata/dbg_rvalid            registered DBG read data and its strobe
//  MEM_*2, MEM_SIZE, MEM_SIGN      memory port 2 request; MEM_DOUT2 read data
module otter_dmem_arbiter
  import otter_arb_pkg::*;
#(
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        cpu_rden,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_din,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_sign,
  output logic [31:0] cpu_dout,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_din,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  output logic        dbg_rvalid,
  output logic        MEM_RDEN2,
  output logic        MEM_WE2,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  input  logic [31:0] MEM_DOUT2
);

  arb_state_t  r_state;
  arb_state_t  w_next_state;
  mem_req_t    w_cpu_req;
  mem_req_t    w_dbg_req;
  mem_req_t    w_port;
  logic        w_cpu_act;
  logic        w_starve;
  logic        w_grant;
  logic [31:0] r_dbg_rdata;
  logic        r_dbg_rvalid;

  assign w_cpu_act = cpu_rden | cpu_we;
  assign w_cpu_req = '{rden: cpu_rden, we: cpu_we, addr: cpu_addr,
                       din: cpu_din, size: cpu_size, sign: cpu_sign};
  assign w_dbg_req = dbg_to_req(dbg_we, dbg_addr, dbg_din);

`ifdef OTTER_ARB_STARVE_EN
  otter_starve_counter #(
    .CNT_W    (CNT_W),
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .CLK      (CLK),
    .RESET    (RESET),
    .i_inc    (dbg_req & ~w_grant),
    .i_clr    (w_grant | ~dbg_req),
    .o_starve (w_starve)
  );
`else
  // No forced slots: DBG only ever gets CPU-idle cycles.
  logic w_unused_cfg;
  assign w_starve     = 1'b0;
  assign w_unused_cfg = (MAX_WAIT == 0) ^ (CNT_W == 0);
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= S_CPU;
      r_dbg_rvalid <= 1'b0;
      r_dbg_rdata  <= '0;
    end else begin
      r_state      <= w_next_state;
      // Memory answers one cycle after the DBG read was issued.
      r_dbg_rvalid <= (r_state == S_DBG_RD);
      if (r_state == S_DBG_RD) begin
        r_dbg_rdata <= MEM_DOUT2;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    case (r_state)
      S_CPU: begin
        w_grant = ~RESET & dbg_req & (~w_cpu_act | w_starve);
        if (w_grant) begin
          w_next_state = dbg_we ? S_DBG_WR : S_DBG_RD;
        end
      end
      // One cycle back to the CPU after every DBG access; enforces spacing.
      S_DBG_RD, S_DBG_WR: w_next_state = S_CPU;
      default:            w_next_state = S_CPU;
    endcase
    w_port = w_grant ? w_dbg_req : w_cpu_req;
  end

  assign MEM_RDEN2  = w_port.rden;
  assign MEM_WE2    = w_port.we;
  assign MEM_ADDR2  = w_port.addr;
  assign MEM_DIN2   = w_port.din;
  assign MEM_SIZE   = w_port.size;
  assign MEM_SIGN   = w_port.sign;

  assign cpu_dout   = MEM_DOUT2;
  assign dbg_ack    = w_grant;
  assign dbg_rdata  = r_dbg_rdata;
  assign dbg_rvalid = r_dbg_rvalid;

`ifdef OTTER_ARB_STARVE_EN
  // The stalled CPU access stays in EX/MEM and is reissued next cycle.
  assign cpu_stall  = w_grant & w_cpu_act;
`else
  assign cpu_stall  = 1'b0;
`endif

endmodule

// File: tb/tb_otter_dmem_arbiter.sv
module tb_otter_dmem_arbiter;

  localparam int MAXW = 8;
`ifdef OTTER_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic        cpu_rden, cpu_we, cpu_sign;
  logic [31:0] cpu_addr, cpu_din, cpu_dout;
  logic [1:0]  cpu_size;
  logic        cpu_stall;
  logic        dbg_req, dbg_we, dbg_ack, dbg_rvalid;
  logic [31:0] dbg_addr, dbg_din, dbg_rdata;
  logic        MEM_RDEN2, MEM_WE2, MEM_SIGN;
  logic [31:0] MEM_ADDR2, MEM_DIN2, MEM_DOUT2;
  logic [1:0]  MEM_SIZE;

  otter_dmem_arbiter #(.MAX_WAIT(MAXW), .CNT_W(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .cpu_rden(cpu_rden), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_size(cpu_size), .cpu_sign(cpu_sign), .cpu_dout(cpu_dout), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_din(dbg_din),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2), .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2),
    .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN), .MEM_DOUT2(MEM_DOUT2)
  );

  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Environment memory (driven by the port) and expected memory contents.
  logic [31:0] mem    [bit [31:0]];
  logic [31:0] shadow [bit [31:0]];

  // Reference model: DBG slots at least 2 cycles apart, consecutive wait count,
  // one outstanding read answered 2 cycles after its grant.
  int          last_ack = -100;
  int          wait_n   = 0;
  bit          pend     = 1'b0;
  int          pend_cyc = 0;
  logic [31:0] pend_data = '0;
  bit          g_q  = 1'b0;
  bit          st_q = 1'b0;
  bit          o_ack, o_stall, o_rvalid;
  logic [31:0] o_rdata;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction
  function automatic logic [31:0] memrd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction
  function automatic logic [31:0] shrd(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : dflt(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    logic        e_grant, e_stall, e_rvalid, e_free, e_starve, e_act;
    logic        s_rst, s_req, s_dwe, s_cwe, p_rd, p_we;
    logic [31:0] s_daddr, s_ddin, s_caddr, s_cdin, p_addr, p_din;
    @(negedge CLK);
    e_act    = cpu_rden || cpu_we;
    e_free   = (cyc - last_ack) >= 2;
    e_starve = STARVE_EN && (wait_n >= MAXW);
    e_grant  = !RESET && e_free && dbg_req && (!e_act || e_starve);
    e_stall  = e_grant && e_act;
    e_rvalid = pend && (cyc == pend_cyc + 2);
    chk("dbg_ack",   32'(dbg_ack),   32'(e_grant));
    chk("cpu_stall", 32'(cpu_stall), 32'(e_stall));
    chk("mem_rden",  32'(MEM_RDEN2), 32'(e_grant ? !dbg_we : cpu_rden));
    chk("mem_we",    32'(MEM_WE2),   32'(e_grant ? dbg_we : cpu_we));
    chk("mem_addr",  MEM_ADDR2,      e_grant ? dbg_addr : cpu_addr);
    chk("mem_din",   MEM_DIN2,       e_grant ? dbg_din : cpu_din);
    chk("mem_size",  32'(MEM_SIZE),  32'(e_grant ? 2'b10 : cpu_size));
    chk("mem_sign",  32'(MEM_SIGN),  32'(e_grant ? 1'b0 : cpu_sign));
    chk("cpu_dout",  cpu_dout,       MEM_DOUT2);
    chk("dbg_rvalid", 32'(dbg_rvalid), 32'(e_rvalid));
    if (e_rvalid) chk("dbg_rdata", dbg_rdata, pend_data);
    o_ack = dbg_ack; o_stall = cpu_stall; o_rvalid = dbg_rvalid; o_rdata = dbg_rdata;
    p_rd = MEM_RDEN2; p_we = MEM_WE2; p_addr = MEM_ADDR2; p_din = MEM_DIN2;
    s_rst = RESET; s_req = dbg_req; s_dwe = dbg_we; s_daddr = dbg_addr; s_ddin = dbg_din;
    s_cwe = cpu_we; s_caddr = cpu_addr; s_cdin = cpu_din;
    @(posedge CLK);
    #1;
    if (p_we) mem[p_addr] = p_din;
    MEM_DOUT2 = p_rd ? memrd(p_addr) : $urandom;
    if (pend && cyc >= pend_cyc + 2) pend = 1'b0;
    if (s_rst) begin
      last_ack = -100; wait_n = 0; pend = 1'b0;
    end else begin
      if (e_grant) begin
        last_ack = cyc;
        if (!s_dwe) begin pend = 1'b1; pend_cyc = cyc; pend_data = shrd(s_daddr); end
      end
      if (e_grant || !s_req) wait_n = 0;
      else if (wait_n < MAXW) wait_n++;
    end
    if (e_grant && s_dwe) shadow[s_daddr] = s_ddin;
    else if (!e_grant && s_cwe) shadow[s_caddr] = s_cdin;
    g_q = e_grant; st_q = e_stall;
    cyc++;
  endtask

  task automatic cpu_idle();
    cpu_rden = 1'b0; cpu_we = 1'b0;
    cpu_addr = $urandom; cpu_din = $urandom;
    cpu_size = 2'($urandom_range(0, 3)); cpu_sign = 1'($urandom_range(0, 1));
  endtask

  initial begin
    int          acks, ofs, rv_ofs, stalls, rvs, last_a, min_sp;
    int          busy;
    logic [31:0] rv_data;
    logic [31:0] wd [3];
    MEM_DOUT2 = '0;
    dbg_we = 1'b0; dbg_din = '0; dbg_addr = 32'h1000;

    // Reset with a pending DBG request and a busy CPU read.
    RESET = 1'b1; dbg_req = 1'b1;
    cpu_idle(); cpu_rden = 1'b1; cpu_addr = 32'h2000;
    step(); step();
    RESET = 1'b0; dbg_req = 1'b0; cpu_idle();
    chk("rst_rdata", dbg_rdata, 32'h0);
    chk("rst_rvalid", 32'(dbg_rvalid), 32'h0);

    // Idle grant: DBG read of 0x1000.
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h1000;
    acks = 0; ofs = -1; rv_ofs = -1; rv_data = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (o_ack) begin acks++; if (ofs < 0) ofs = i; end
      if (o_rvalid) begin rv_ofs = i; rv_data = o_rdata; end
      if (g_q) dbg_req = 1'b0;
    end
    chk("idle_ofs", ofs, 0);
    chk("idle_acks", acks, 1);
    chk("idle_rv_ofs", rv_ofs, 2);
    chk("idle_rdata", rv_data, dflt(32'h1000));

    // CPU priority: three CPU stores while DBG waits.
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h1044;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      wd[i] = $urandom;
      cpu_rden = 1'b0; cpu_we = 1'b1; cpu_addr = 32'h1040 + 32'(i * 4); cpu_din = wd[i];
      step();
      if (o_ack) acks++;
      if (g_q) dbg_req = 1'b0;
    end
    chk("prio_no_ack", acks, 0);
    cpu_idle(); ofs = -1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (o_ack && ofs < 0) ofs = i;
      if (g_q) dbg_req = 1'b0;
    end
    chk("prio_idle_ofs", ofs, 0);
    for (int i = 0; i < 3; i++) chk("store_intact", memrd(32'h1040 + 32'(i * 4)), wd[i]);

    // Starvation: CPU reads continuously, DBG writes 0xDEADBEEF.
    cpu_rden = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1080;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h1050; dbg_din = 32'hDEAD_BEEF;
    ofs = -1; stalls = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (o_ack && ofs < 0) ofs = i;
      if (o_stall) stalls++;
      if (g_q) dbg_req = 1'b0;
    end
    chk("starve_ofs", ofs, STARVE_EN ? 8 : -1);
    chk("starve_stalls", stalls, STARVE_EN ? 1 : 0);
    cpu_idle();
    for (int i = 0; i < 4; i++) begin
      step();
      if (g_q) dbg_req = 1'b0;
    end
    chk("dbg_wr_intact", memrd(32'h1050), 32'hDEAD_BEEF);

    // Back-to-back DBG writes with the CPU idle.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h1060; dbg_din = $urandom;
    acks = 0; last_a = -100; min_sp = 100;
    for (int i = 0; i < 12; i++) begin
      step();
      if (o_ack) begin
        acks++;
        if (i - last_a < min_sp) min_sp = i - last_a;
        last_a = i;
      end
      if (g_q) begin dbg_addr = dbg_addr + 32'd4; dbg_din = $urandom; end
    end
    dbg_req = 1'b0;
    chk("b2b_min_spacing", min_sp, 2);
    chk("b2b_acks", acks, 6);
    step();

    // Reset while a DBG read is in flight drops its rvalid.
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h1044;
    acks = 0;
    for (int i = 0; i < 4 && !g_q; i++) begin
      step();
      if (o_ack) acks++;
    end
    chk("rdrst_ack", acks, 1);
    dbg_req = 1'b0; RESET = 1'b1;
    step();
    RESET = 1'b0; rvs = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (o_rvalid) rvs++;
    end
    chk("rdrst_no_rvalid", rvs, 0);
    dbg_req = 1'b1; dbg_addr = 32'h1048; rvs = 0; rv_data = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (g_q) dbg_req = 1'b0;
      if (o_rvalid) begin rvs++; rv_data = o_rdata; end
    end
    chk("rdrst_next_rvalid", rvs, 1);
    chk("rdrst_next_rdata", rv_data, wd[2]);

    // Randomized traffic: moderate then heavy CPU load, occasional resets.
    for (int i = 0; i < 500; i++) begin
      busy = (i < 250) ? 6 : 19;
      if (!st_q) begin
        int r;
        r = $urandom_range(0, 19);
        cpu_rden = (r < busy) && (r % 3 != 0);
        cpu_we   = (r < busy) && (r % 3 == 0);
        cpu_addr = 32'h1000 + 32'($urandom_range(0, 15) * 4);
        cpu_din  = $urandom;
        cpu_size = 2'($urandom_range(0, 3));
        cpu_sign = 1'($urandom_range(0, 1));
      end
      if (g_q || !dbg_req) begin
        if ($urandom_range(0, 2) == 0) begin
          dbg_req  = 1'b1;
          dbg_we   = 1'($urandom_range(0, 1));
          dbg_addr = 32'h1000 + 32'($urandom_range(0, 15) * 4);
          dbg_din  = $urandom;
        end else begin
          dbg_req = 1'b0;
        end
      end else if ($urandom_range(0, 39) == 0) begin
        dbg_req = 1'b0;
      end
      RESET = ($urandom_range(0, 49) == 0);
      step();
    end
    RESET = 1'b0; dbg_req = 1'b0; cpu_idle();
    step(); step(); step();

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
